// File: rtl/dcache_ctrl_if.sv
// Bus interfaces for the data-cache controller.
//   dcache_cpu_if : CPU data port (CPU is master, cache is slave).
//   dcache_mem_if : line-wide main-memory port (cache is master, memory is slave).

interface dcache_cpu_if;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        re;
  logic        we;
  logic [15:0] rd_data;
  logic        rdy;

  modport master (output addr, wr_data, re, we, input rd_data, rdy);
  modport slave  (input addr, wr_data, re, we, output rd_data, rdy);
endinterface

interface dcache_mem_if;
  logic [13:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [63:0] m_wr_data;
  logic [63:0] m_rd_data;
  logic        m_rdy;

  modport master (output m_addr, m_re, m_we, m_wr_data, input m_rd_data, m_rdy);
  modport slave  (input m_addr, m_re, m_we, m_wr_data, output m_rd_data, m_rdy);
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 4 x 16-bit words per line; hits complete in the request cycle, misses
// stall the CPU while a dirty victim is written back and the line is filled.

module dcache_ctrl #(
  parameter int INDEX_BITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_cpu_if.slave   cpu,
  dcache_mem_if.master  mem,
  output logic [15:0]   miss_cnt_o
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 14 - INDEX_BITS;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [INDEX_BITS-1:0] idx_t;

  // Line storage and per-line state
  logic [15:0]      data_q [LINES][4];
  tag_t             tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;

  // Controller state
  logic [1:0]  state_q, state_d;
  logic [13:0] req_line_q, req_line_d;   // {tag,index} of the missing request
  logic [13:0] m_addr_q, m_addr_d;
  logic [63:0] m_wr_data_q, m_wr_data_d;
  logic        m_re_q, m_re_d;
  logic        m_we_q, m_we_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Datapath controls
  logic        store_wr;
  logic        fill_wr;
  logic        rdy;
  logic [15:0] rd_data;

  // Address decode of the live CPU request and of the captured miss
  logic [1:0] cpu_off;
  idx_t       cpu_idx;
  tag_t       cpu_tag;
  idx_t       req_idx;
  tag_t       req_tag;
  logic       req_any;
  logic       hit;

  assign cpu_off = cpu.addr[1:0];
  assign cpu_idx = cpu.addr[INDEX_BITS+1:2];
  assign cpu_tag = cpu.addr[15:INDEX_BITS+2];
  assign req_idx = req_line_q[INDEX_BITS-1:0];
  assign req_tag = req_line_q[13:INDEX_BITS];
  assign req_any = cpu.re | cpu.we;
  assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // Next-state, handshake and hit/miss decision
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    req_line_d  = req_line_q;
    m_addr_d    = m_addr_q;
    m_wr_data_d = m_wr_data_q;
    m_re_d      = m_re_q;
    m_we_d      = m_we_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    store_wr    = 1'b0;
    fill_wr     = 1'b0;
    rdy         = 1'b0;
    rd_data     = 16'h0000;

    case (state_q)
      ST_IDLE: begin
        rdy = !(req_any && !hit);
        if (cpu.re && hit) begin
          rd_data = data_q[cpu_idx][cpu_off];
        end
        if (req_any && hit) begin
          // re+we together is treated as a store
          if (cpu.we) begin
            store_wr         = 1'b1;
            dirty_d[cpu_idx] = 1'b1;
          end
        end else if (req_any) begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          req_line_d = cpu.addr[15:2];
          if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
            state_d     = ST_WRITEBACK;
            m_we_d      = 1'b1;
            m_addr_d    = {tag_q[cpu_idx], cpu_idx};
            m_wr_data_d = {data_q[cpu_idx][3], data_q[cpu_idx][2],
                           data_q[cpu_idx][1], data_q[cpu_idx][0]};
          end else begin
            state_d  = ST_ALLOCATE;
            m_re_d   = 1'b1;
            m_addr_d = cpu.addr[15:2];
          end
        end
      end

      ST_WRITEBACK: begin
        if (mem.m_rdy) begin
          dirty_d[req_idx] = 1'b0;
          m_we_d           = 1'b0;
          m_re_d           = 1'b1;
          m_addr_d         = req_line_q;
          state_d          = ST_ALLOCATE;
        end
      end

      ST_ALLOCATE: begin
        if (mem.m_rdy) begin
          fill_wr          = 1'b1;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          m_re_d           = 1'b0;
          state_d          = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and line status registers
  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_line_q  <= '0;
      m_addr_q    <= '0;
      m_wr_data_q <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_line_q  <= req_line_d;
      m_addr_q    <= m_addr_d;
      m_wr_data_q <= m_wr_data_d;
      m_re_q      <= m_re_d;
      m_we_q      <= m_we_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Line data and tag storage: line fill or single-word store merge
  // NOTE: no reset on the storage arrays; valid_q guards their contents, so they map to plain RAM.
  always_ff @(posedge clk) begin
    if (fill_wr) begin
      for (int w = 0; w < 4; w++) begin
        data_q[req_idx][w] <= mem.m_rd_data[16*w +: 16];
      end
      tag_q[req_idx] <= req_tag;
    end else if (store_wr) begin
      data_q[cpu_idx][cpu_off] <= cpu.wr_data;
    end
  end

  assign cpu.rdy       = rdy;
  assign cpu.rd_data   = rd_data;
  assign mem.m_addr    = m_addr_q;
  assign mem.m_re      = m_re_q;
  assign mem.m_we      = m_we_q;
  assign mem.m_wr_data = m_wr_data_q;
  assign miss_cnt_o    = miss_cnt_q;

endmodule
